// File: rtl/cpu_csr_pkg.sv
// Shared CSR definitions: Zicsr funct3 codes, counter CSR addresses, privilege
// encodings and the W-stage register layout used by cpu_csr_unit.
package cpu_csr_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_ILL0 = 3'b000,
    F3_RW   = 3'b001,
    F3_RS   = 3'b010,
    F3_RC   = 3'b011,
    F3_ILL4 = 3'b100,
    F3_RWI  = 3'b101,
    F3_RSI  = 3'b110,
    F3_RCI  = 3'b111
  } csr_funct3_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  // The CSR file post-increments these, so a W value is stale by the time E reads it.
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef struct packed {
    logic            valid;
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
  } w_reg_t;

  function automatic logic is_counter(input logic [11:0] addr);
    return (addr == CSR_MCYCLE)  || (addr == CSR_MINSTRET) ||
           (addr == CSR_MCYCLEH) || (addr == CSR_MINSTRETH);
  endfunction

endpackage

// File: rtl/cpu_csr_alu.sv
// Zicsr read-modify-write datapath: computes the new CSR value and whether the
// instruction intends to write at all (RS/RC forms skip the write when rs1/uimm field is zero).
module cpu_csr_alu
  import cpu_csr_pkg::*;
(
  input  csr_funct3_e     funct3_i,
  input  logic [4:0]      zimm_i,
  input  logic [XLEN-1:0] src_i,
  input  logic [XLEN-1:0] old_i,
  output logic [XLEN-1:0] new_o,
  output logic            wr_intent_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    new_o       = old_i;
    wr_intent_o = 1'b0;
    unique case (funct3_i)
      F3_RW, F3_RWI: begin
        new_o       = src_i;
        wr_intent_o = 1'b1;
      end
      F3_RS, F3_RSI: begin
        new_o       = old_i | src_i;
        wr_intent_o = (zimm_i != 5'd0);
      end
      F3_RC, F3_RCI: begin
        new_o       = old_i & ~src_i;
        wr_intent_o = (zimm_i != 5'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_csr_unit.sv
// Zicsr access initiator: E-stage decode, read and legality check; W-stage commit.
// Define CPU_CSR_FORWARD_EN to forward non-counter W->E hits instead of stalling on them.
module cpu_csr_unit
  import cpu_csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            e_valid,
  input  logic [2:0]      e_funct3,
  input  logic [11:0]     e_csr,
  input  logic [XLEN-1:0] e_rs1,
  input  logic [4:0]      e_zimm,
  input  logic [1:0]      priv,
  input  logic            advance,
  input  logic            flush_w,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] e_result,
  output logic            e_illegal,
  output logic            e_stall,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_wenable
);

  csr_funct3_e     funct3;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            wr_intent;
  logic            hit;
  logic            fwd;
  logic            funct3_bad;
  logic            priv_bad;
  logic            ro_bad;
  w_reg_t          w_q;
  w_reg_t          w_d;

  assign funct3    = csr_funct3_e'(e_funct3);
  assign src       = e_funct3[2] ? {{(XLEN-5){1'b0}}, e_zimm} : e_rs1;
  assign csr_raddr = e_csr;

  // A flushed W instruction never counts as a hit, so E falls back to the file value.
  assign hit = w_q.valid & ~flush_w & e_valid & (w_q.addr == e_csr);

`ifdef CPU_CSR_FORWARD_EN
  assign e_stall = hit & is_counter(e_csr);
  assign fwd     = hit & ~is_counter(e_csr);
`else
  assign e_stall = hit;
  assign fwd     = 1'b0;
`endif

  assign old_val  = fwd ? w_q.data : csr_rdata;
  assign e_result = old_val;

  cpu_csr_alu u_alu (
    .funct3_i    (funct3),
    .zimm_i      (e_zimm),
    .src_i       (src),
    .old_i       (old_val),
    .new_o       (new_val),
    .wr_intent_o (wr_intent)
  );

  assign funct3_bad = (funct3 == F3_ILL0) || (funct3 == F3_ILL4);
  assign priv_bad   = (e_csr[9:8] > priv);
  assign ro_bad     = (e_csr[11:10] == 2'b11) & wr_intent;
  assign e_illegal  = e_valid & (funct3_bad | priv_bad | ro_bad);

  always_comb begin
    w_d = w_q;
    if (advance) begin
      w_d.valid = e_valid & wr_intent & ~e_illegal & ~e_stall & ~flush_w;
      w_d.addr  = e_csr;
      w_d.data  = new_val;
    end else if (flush_w) begin
      w_d.valid = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign csr_wenable = w_q.valid & ~flush_w;
  assign csr_waddr   = w_q.addr;
  assign csr_wdata   = w_q.data;

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Randomized scoreboard bench for cpu_csr_unit: an architectural CSR model predicts
// each instruction's read value and each committed write; a monitor compares them.
`timescale 1ns/1ps
module tb_cpu_csr_unit;
  import cpu_csr_pkg::*;

`ifdef CPU_CSR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            e_valid;
  logic [2:0]      e_funct3;
  logic [11:0]     e_csr;
  logic [XLEN-1:0] e_rs1;
  logic [4:0]      e_zimm;
  logic [1:0]      priv;
  logic            advance;
  logic            flush_w;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] e_result;
  logic            e_illegal;
  logic            e_stall;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wenable;

  always #5 clk = ~clk;

  cpu_csr_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .e_valid     (e_valid),
    .e_funct3    (e_funct3),
    .e_csr       (e_csr),
    .e_rs1       (e_rs1),
    .e_zimm      (e_zimm),
    .priv        (priv),
    .advance     (advance),
    .flush_w     (flush_w),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .e_result    (e_result),
    .e_illegal   (e_illegal),
    .e_stall     (e_stall),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .csr_wenable (csr_wenable)
  );

  // Bench-side CSR file: combinational read, write on the clock edge.
  function automatic logic [31:0] seed(input logic [11:0] a);
    if (a == 12'h340) return 32'h0000_0012;
    if (a == 12'h341) return 32'h0000_00F0;
    return {a, ~a, 8'hC3};
  endfunction

  logic [31:0] file_mem [4096];
  logic        file_init = 1'b1;
  assign csr_rdata = file_mem[csr_raddr];

  always @(posedge clk) begin
    if (file_init) begin
      for (int i = 0; i < 4096; i++) file_mem[i] <= seed(12'(i));
    end else if (csr_wenable) begin
      file_mem[csr_waddr] <= csr_wdata;
    end
  end

  // Architectural model and scoreboard.
  typedef struct { logic [31:0] result; logic illegal; } res_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;

  logic [31:0] arch [4096];
  res_t        res_q [$];
  wr_t         wr_q  [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  bit          flush_now  = 1'b0;
  bit          pend_valid = 1'b0;
  logic [11:0] pend_addr  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (e_valid && !e_stall && advance) begin
        if (res_q.size() == 0) begin
          check("unexpected_accept_count", 32'(res_q.size()), 32'd1);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("e_result", e_result, r.result);
          check("e_illegal", 32'(e_illegal), 32'(r.illegal));
        end
      end
      if (csr_wenable) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write_count", 32'(wr_q.size()), 32'd1);
        end else begin
          check("csr_waddr", 32'(csr_waddr), 32'(wr_q[0].addr));
          check("csr_wdata", csr_wdata, wr_q[0].data);
          if (advance) void'(wr_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit exp_stall);
    @(negedge clk);
    check("e_stall", 32'(e_stall), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    e_valid = 1'b0;
    advance = 1'b1;
    flush_w = flush_now;
    flush_now  = 1'b0;
    pend_valid = 1'b0;
    @(negedge clk);
    check("idle_e_stall", 32'(e_stall), 32'd0);
    check("idle_e_illegal", 32'(e_illegal), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] zimm, input logic [1:0] pv, input int gap,
                       input int holds, input bit flush_after, input bit drop_write);
    logic [31:0] src;
    logic [31:0] old_v;
    logic [31:0] new_v;
    bit          is_rw, is_rs, is_rc, wi, ill, writes, exp_stall, counter;
    for (int g = 0; g < gap; g++) idle_cycle();

    is_rw   = (f3 == 3'b001) || (f3 == 3'b101);
    is_rs   = (f3 == 3'b010) || (f3 == 3'b110);
    is_rc   = (f3 == 3'b011) || (f3 == 3'b111);
    src     = f3[2] ? {27'd0, zimm} : rs1;
    old_v   = arch[a];
    new_v   = is_rw ? src : is_rs ? (old_v | src) : is_rc ? (old_v & ~src) : old_v;
    wi      = is_rw || ((is_rs || is_rc) && zimm != 5'd0);
    ill     = !(is_rw || is_rs || is_rc) || (a[9:8] > pv) || (a[11:10] == 2'b11 && wi);
    writes  = !ill && wi && !flush_now && !flush_after && !drop_write;
    counter = (a == 12'hB00) || (a == 12'hB02) || (a == 12'hB80) || (a == 12'hB82);
    exp_stall = pend_valid && !flush_now && (pend_addr == a) && (counter || !FWD);

    res_q.push_back('{result: old_v, illegal: ill});
    if (writes) begin
      wr_q.push_back('{addr: a, data: new_v});
      arch[a] = new_v;
    end

    e_valid = 1'b1; e_funct3 = f3; e_csr = a; e_rs1 = rs1; e_zimm = zimm; priv = pv;
    if (!flush_now) begin
      for (int h = 0; h < holds; h++) begin
        advance = 1'b0; flush_w = 1'b0;
        cyc(exp_stall);
      end
    end
    if (exp_stall) begin
      advance = 1'b1; flush_w = 1'b0;
      cyc(1'b1);
    end
    advance = 1'b1; flush_w = flush_now;
    cyc(1'b0);
    flush_now  = flush_after;
    pend_valid = writes;
    pend_addr  = a;
  endtask

  logic [11:0] addrs [10] = '{12'h340, 12'h341, 12'h305, 12'h300, 12'hF11,
                              12'hB00, 12'hB02, 12'hB80, 12'h140, 12'hC00};

  initial begin
    logic [11:0] a, last_a;
    logic [1:0]  pv;
    logic [4:0]  zimm;
    e_valid = 1'b0; e_funct3 = 3'b001; e_csr = 12'h340; e_rs1 = '0; e_zimm = '0;
    priv = 2'b11; advance = 1'b1; flush_w = 1'b0;
    for (int i = 0; i < 4096; i++) arch[i] = seed(12'(i));

    @(posedge clk); #1;
    @(negedge clk);
    check("reset_csr_wenable", 32'(csr_wenable), 32'd0);
    check("reset_e_stall", 32'(e_stall), 32'd0);
    check("reset_e_illegal", 32'(e_illegal), 32'd0);
    e_valid = 1'b1;
    #1;
    check("reset_valid_e_stall", 32'(e_stall), 32'd0);
    check("reset_valid_wenable", 32'(csr_wenable), 32'd0);
    e_valid = 1'b0;
    @(posedge clk); #1;
    file_init = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd7, 2'b11, 1, 0, 1'b0, 1'b0);
    issue(3'b010, 12'h341, 32'h0000_000F, 5'd1, 2'b11, 1, 0, 1'b0, 1'b0);
    issue(3'b011, 12'h341, 32'h0000_0003, 5'd2, 2'b11, 0, 0, 1'b0, 1'b0);
    issue(3'b110, 12'hF11, 32'h0,         5'd0, 2'b11, 1, 0, 1'b0, 1'b0);
    issue(3'b001, 12'hF11, 32'h1234_5678, 5'd4, 2'b11, 1, 0, 1'b0, 1'b0);
    issue(3'b001, 12'h300, 32'h0000_0008, 5'd4, 2'b00, 1, 0, 1'b0, 1'b0);
    issue(3'b001, 12'h305, 32'h0000_0100, 5'd9, 2'b11, 1, 0, 1'b1, 1'b0);
    issue(3'b010, 12'h305, 32'h0,         5'd0, 2'b11, 0, 0, 1'b0, 1'b0);
    issue(3'b001, 12'hB00, 32'h0000_1000, 5'd3, 2'b11, 1, 0, 1'b0, 1'b0);
    issue(3'b010, 12'hB00, 32'h0000_0001, 5'd3, 2'b11, 0, 0, 1'b0, 1'b0);

    last_a = 12'h340;
    for (int n = 0; n < 400; n++) begin
      a    = ($urandom_range(1) == 1) ? last_a : addrs[$urandom_range(9)];
      pv   = ($urandom_range(3) == 0) ? 2'($urandom_range(1)) : 2'b11;
      zimm = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      issue(3'($urandom_range(7)), a, $urandom, zimm, pv,
            ($urandom_range(2) == 0) ? 1 : 0,
            ($urandom_range(4) == 0) ? 1 : 0,
            ($urandom_range(9) == 0), 1'b0);
      last_a = a;
    end

    for (int i = 0; i < 3; i++) idle_cycle();
    check("result_queue_drained", 32'(res_q.size()), 32'd0);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);

    issue(3'b001, 12'h340, 32'hA5A5_0F0F, 5'd3, 2'b11, 0, 0, 1'b0, 1'b1);
    e_valid = 1'b0;
    check("pending_write_visible", 32'(csr_wenable), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("reset_drops_wenable", 32'(csr_wenable), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_write_never_lands", file_mem[12'h340], arch[12'h340]);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_wenable", 32'(csr_wenable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_csr_unit.md
# cpu_csr_unit

Pipelined CSR access initiator: decodes Zicsr instructions in the execute (E) stage, reads the CSR file, computes the read-modify-write value and commits it from the writeback (W) stage through the CSR file's write port. Performs privilege and read-only checks and flags illegal accesses. Handles back-to-back E/W hazards by forwarding or stalling. Sits between the E/W pipeline registers and the machine-mode CSR file.

## Interface
- XLEN, 32, data width.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- e_valid  in  1  CSR instruction present in E.
- e_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- e_csr  in  12  CSR address.
- e_rs1  in  XLEN  rs1 register value.
- e_zimm  in  5  rs1 field; used as uimm for *I ops and as the zero test for RS/RC.
- priv  in  2  current privilege level.
- advance  in  1  pipeline advances E→W this cycle.
- flush_w  in  1  kill the W-stage instruction (trap at W).
- csr_raddr  out  12  CSR file read address; equals e_csr.
- csr_rdata  in  XLEN  CSR file read data, combinational.
- e_result  out  XLEN  old CSR value written to rd.
- e_illegal  out  1  illegal-instruction exception request for E.
- e_stall  out  1  hold E, insert a bubble into W.
- csr_waddr  out  12; csr_wdata  out  XLEN; csr_wenable  out  1  CSR file write port.

## Operation
- Source operand: RW/RS/RC use e_rs1; *I ops use zero-extended e_zimm.
- New value: RW = src; RS = old | src; RC = old & ~src.
- Write intent: RW/RWI always; RS/RC/RSI/RCI only if e_zimm != 0.
- e_illegal = e_valid & (funct3 ∈ {000,100} | e_csr[9:8] > priv | (e_csr[11:10] == 2'b11 & write intent)). Reads of read-only CSRs are legal.
- W register (w_valid, w_addr, w_data) loads on advance: w_valid ← e_valid & write intent & ~e_illegal & ~e_stall & ~flush_w. When advance is low, the register holds, except flush_w, which clears w_valid.
- csr_wenable = w_valid & ~flush_w. csr_waddr = w_addr. csr_wdata = w_data.
- Hazard: a hit is w_valid & ~flush_w & w_addr == e_csr & e_valid.
- Counter CSRs 0xB00, 0xB02, 0xB80, 0xB82 (the file post-increments them) are never forwarded; a hit on these always asserts e_stall.
- Old value: on a forwarded hit, old = w_data; otherwise old = csr_rdata. e_result = old.

## Timing
- Reset (async): w_valid=0, w_addr=0, w_data=0. Outputs: csr_wenable=0, e_stall=0, e_illegal=0 when e_valid=0.
- E→W latency: 1 advancing cycle. The CSR file sees the write on the edge that ends W.
- A stall lasts exactly 1 cycle. The bubble clears w_valid, so the hazard cannot repeat.
- flush_w and a hit in the same cycle: no hit. E reads csr_rdata directly.
- e_illegal together with e_stall: e_illegal is reported. The trap logic flushes E.
- Reset mid-W: the pending write is dropped and never reaches the file.

## Configuration
- CPU_CSR_FORWARD_EN defined: non-counter hits forward w_data with no stall.
- CPU_CSR_FORWARD_EN undefined: every hit asserts e_stall for 1 cycle. E re-reads the committed value on the next cycle.

## Structure
- Shared CSR header: funct3 codes, CSR address defines including the counter addresses, and privilege encodings.
- One combinational sub-module, cpu_csr_alu: (funct3, src, old) → new value and write intent.
- The top module holds the W register, hazard detection, the illegal check and the stall logic.

## Test plan
- CSRRW 0x340 (mscratch), rs1=0xDEADBEEF, old value 0x12 → e_result=0x12. Next cycle: csr_wenable=1, waddr=0x340, wdata=0xDEADBEEF.
- CSRRS mepc, rs1=0x0F, then CSRRC mepc, rs1=0x03 back-to-back (old 0xF0) → second e_result=0xFF, second wdata=0xFC. Forwarding build: no stall. Non-forwarding build: e_stall for exactly 1 cycle.
- CSRRSI with zimm=0 on 0xF11 (read-only) → no illegal, e_result=csr_rdata, csr_wenable stays 0.
- CSRRW 0xF11 → e_illegal=1, no write. CSRRW 0x300 with priv=U → e_illegal=1.
- CSRRW mtvec=0x100 in W with flush_w=1 → csr_wenable=0, and the next E read of mtvec uses csr_rdata without a stall.
- CSRRW mcycle followed by CSRRS mcycle → e_stall=1 in both builds. rst_n pulsed low while W is valid → csr_wenable=0 immediately.
